// File: rtl/noc_packet_injector.sv
// NoC local-port packet injector: turns a packet request plus a payload
// word stream into head/body/tail flits with per-VC credit flow control.
//
// Ports:
//   noc_clk, noc_rst_n      clock, async active-low reset
//   id_x, id_y              own node coordinates (static)
//   req_*                   packet request (dst, len, vc), valid/ready
//   data_*                  payload word stream, valid/ready
//   flit_*                  flit stream toward the router local port
//   credit_return           per-VC pulse for each freed router slot
//   credit_err              sticky credit overflow flag
//   pkt_sent                pulse on the last flit transfer of a packet
module noc_packet_injector #(
  parameter int FLIT_W    = 64,
  parameter int ID_X_W    = 3,
  parameter int ID_Y_W    = 3,
  parameter int LEN_W     = 4,
  parameter int VC_NUM    = 2,
  parameter int BUF_DEPTH = 4,
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic [ID_X_W-1:0] id_x,
  input  logic [ID_Y_W-1:0] id_y,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_X_W-1:0] req_dst_x,
  input  logic [ID_Y_W-1:0] req_dst_y,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [VW-1:0]     req_vc,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [FLIT_W-3:0] data_word,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [VW-1:0]     flit_vc,
  output logic [FLIT_W-1:0] flit_data,
  input  logic [VC_NUM-1:0] credit_return,
  output logic              credit_err,
  output logic              pkt_sent
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = FLIT_W - 2;
  localparam int HW = 2 * ID_X_W + 2 * ID_Y_W + LEN_W;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY
  } state_t;

  state_t state_q, state_d;

  logic [ID_X_W-1:0] dst_x_q;
  logic [ID_Y_W-1:0] dst_y_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rem_q;
  logic [VW-1:0]     vc_q;
  logic              run_q;

  logic [CW-1:0]     credit_q [VC_NUM];
  logic              err_q;

  logic              has_credit;
  logic              flit_fire;
  logic              req_fire;
  logic [VC_NUM-1:0] tx_vc;
  logic [PW-1:0]     head_pl;

  assign has_credit = (credit_q[vc_q] != '0);
  assign flit_fire  = flit_valid && flit_ready;
  assign req_fire   = req_valid && req_ready;
  assign flit_vc    = vc_q;
  assign credit_err = err_q;

  assign head_pl = {dst_x_q, dst_y_q, id_x, id_y, len_q,
                    {(PW - HW){1'b0}}};

  always_comb begin
    tx_vc = '0;
    if (flit_fire) tx_vc[vc_q] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    data_ready = 1'b0;
    flit_valid = 1'b0;
    flit_data  = '0;
    pkt_sent   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // held low until the first clock after reset release
        req_ready = run_q;
        if (req_valid && run_q) state_d = HEAD;
      end
      HEAD: begin
        flit_valid = has_credit;
        flit_data  = {(len_q == '0) ? T_HT : T_HEAD, head_pl};
        if (flit_fire) begin
          if (len_q == '0) begin
            pkt_sent = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = BODY;
          end
        end
      end
      BODY: begin
        flit_valid = data_valid && has_credit;
        data_ready = flit_ready && has_credit;
        flit_data  = {(rem_q == LEN_W'(1)) ? T_TAIL : T_BODY,
                      data_word};
        if (flit_fire && rem_q == LEN_W'(1)) begin
          pkt_sent = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      dst_x_q <= '0;
      dst_y_q <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (req_fire) begin
        dst_x_q <= req_dst_x;
        dst_y_q <= req_dst_y;
        len_q   <= req_len;
        rem_q   <= req_len;
        vc_q    <= req_vc;
      end else if (state_q == BODY && flit_fire) begin
        rem_q <= rem_q - LEN_W'(1);
      end
    end
  end

  // A send and a return on the same VC in one cycle cancel out;
  // a return on a full counter saturates and flags the overflow.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int v = 0; v < VC_NUM; v++) begin
        credit_q[v] <= CW'(BUF_DEPTH);
      end
      err_q <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (tx_vc[v] && !credit_return[v]) begin
          credit_q[v] <= credit_q[v] - CW'(1);
        end else if (!tx_vc[v] && credit_return[v]) begin
          if (credit_q[v] == CW'(BUF_DEPTH)) begin
            err_q <= 1'b1;
          end else begin
            credit_q[v] <= credit_q[v] + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector: head-only, multi-flit,
// credit stall, credit overflow, random backpressure, mid-packet reset.
module tb_noc_packet_injector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  id_x = 3'd1;
  logic [2:0]  id_y = 3'd2;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_dst_x = '0;
  logic [2:0]  req_dst_y = '0;
  logic [3:0]  req_len = '0;
  logic        req_vc = 1'b0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [61:0] data_word = '0;
  logic        flit_valid;
  logic        flit_ready = 1'b1;
  logic        flit_vc;
  logic [63:0] flit_data;
  logic [1:0]  credit_return = '0;
  logic        credit_err;
  logic        pkt_sent;

  always #5 clk = ~clk;

  noc_packet_injector dut (
    .noc_clk       (clk),
    .noc_rst_n     (rst_n),
    .id_x          (id_x),
    .id_y          (id_y),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dst_x     (req_dst_x),
    .req_dst_y     (req_dst_y),
    .req_len       (req_len),
    .req_vc        (req_vc),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .data_word     (data_word),
    .flit_valid    (flit_valid),
    .flit_ready    (flit_ready),
    .flit_vc       (flit_vc),
    .flit_data     (flit_data),
    .credit_return (credit_return),
    .credit_err    (credit_err),
    .pkt_sent      (pkt_sent)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hd(
    input logic [2:0] dx, input logic [2:0] dy,
    input logic [2:0] sx, input logic [2:0] sy,
    input logic [3:0] ln, input logic [1:0] t);
    return {t, dx, dy, sx, sy, ln, 46'b0};
  endfunction

  function automatic logic [63:0] bd(input logic [1:0] t,
                                     input logic [61:0] w);
    return {t, w};
  endfunction

  function automatic logic [61:0] wd(input int i);
    return {30'h2AAA_AAAA, 32'(i * 7 + 1)};
  endfunction

  logic [63:0] fq [$];
  logic        vq [$];
  logic [61:0] dq [$];
  int          npkt = 0;
  bit          fired = 0;
  bit          xfer_d = 0;
  logic        xvc_d = 1'b0;
  bit          hold_prev = 0;
  logic [63:0] prev_data = '0;
  bit          tog_en = 0;
  bit          rnd_en = 0;
  bit          stab_en = 0;
  bit          auto_ret = 0;
  logic        fr_man = 1'b1;
  logic [1:0]  man_ret = '0;

  // monitor: transfers happen at the next posedge
  always @(negedge clk) begin
    fired  = data_valid && data_ready;
    xfer_d = flit_valid && flit_ready;
    xvc_d  = flit_vc;
    if (flit_valid && flit_ready) begin
      fq.push_back(flit_data);
      vq.push_back(flit_vc);
    end
    if (pkt_sent) npkt++;
    if (stab_en && hold_prev) begin
      chk("hold_valid", 64'(flit_valid), 64'(1));
      chk("hold_data", flit_data, prev_data);
    end
    hold_prev = flit_valid && !flit_ready;
    prev_data = flit_data;
  end

  // payload source, router ready and credit return driver
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (fired && dq.size() > 0) begin
        void'(dq.pop_front());
        data_valid = 1'b0;
      end
      if (dq.size() == 0) begin
        data_valid = 1'b0;
      end else if (!data_valid &&
                   (!tog_en || $urandom_range(1, 0) == 1)) begin
        data_valid = 1'b1;
        data_word  = dq[0];
      end
      flit_ready = rnd_en ? ($urandom_range(1, 0) == 1) : fr_man;
      credit_return = man_ret;
      if (auto_ret && xfer_d) credit_return[xvc_d] = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [2:0] dx, input logic [2:0] dy,
                          input logic [3:0] ln, input logic v);
    int k = 0;
    req_valid = 1'b1;
    req_dst_x = dx;
    req_dst_y = dy;
    req_len   = ln;
    req_vc    = v;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    chk("req_accept", 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_pkt(input int target, input int bound);
    int k = 0;
    while (npkt < target && k < bound) begin
      tick();
      k++;
    end
    chk("pkt_done", 64'(npkt), 64'(target));
  endtask

  task automatic clear_log();
    fq.delete();
    vq.delete();
  endtask

  initial begin
    int base;
    int ones;

    // reset
    repeat (3) tick();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_flit_valid", 64'(flit_valid), 64'(0));
    chk("rst_data_ready", 64'(data_ready), 64'(0));
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_req_ready", 64'(req_ready), 64'(1));
    chk("idle_err", 64'(credit_err), 64'(0));
    chk("idle_cred0", 64'(dut.credit_q[0]), 64'(4));
    chk("idle_cred1", 64'(dut.credit_q[1]), 64'(4));

    // head-only packet
    clear_log();
    send_req(3'd3, 3'd0, 4'd0, 1'b0);
    chk("t1_latency", 64'(flit_valid), 64'(1));
    tick();
    chk("t1_count", 64'(fq.size()), 64'(1));
    chk("t1_flit", fq[0], hd(3, 0, 1, 2, 0, 2'b11));
    chk("t1_vc", 64'(vq[0]), 64'(0));
    chk("t1_pkt", 64'(npkt), 64'(1));
    chk("t1_cred0", 64'(dut.credit_q[0]), 64'(3));
    chk("t1_idle", 64'(req_ready), 64'(1));

    // three-word packet on vc1
    clear_log();
    dq = '{wd(1), wd(2), wd(3)};
    send_req(3'd2, 3'd3, 4'd3, 1'b1);
    wait_pkt(2, 50);
    chk("t2_count", 64'(fq.size()), 64'(4));
    chk("t2_head", fq[0], hd(2, 3, 1, 2, 3, 2'b00));
    chk("t2_b0", fq[1], bd(2'b01, wd(1)));
    chk("t2_b1", fq[2], bd(2'b01, wd(2)));
    chk("t2_tail", fq[3], bd(2'b10, wd(3)));
    ones = 0;
    foreach (vq[i]) ones += int'(vq[i]);
    chk("t2_vc", 64'(ones), 64'(4));
    chk("t2_cred1", 64'(dut.credit_q[1]), 64'(0));
    man_ret = 2'b11;
    tick();
    man_ret = 2'b10;
    repeat (3) tick();
    man_ret = 2'b00;
    tick();
    chk("t2_ret0", 64'(dut.credit_q[0]), 64'(4));
    chk("t2_ret1", 64'(dut.credit_q[1]), 64'(4));
    chk("t2_err", 64'(credit_err), 64'(0));

    // credit exhaustion stall
    clear_log();
    dq = '{wd(11), wd(12), wd(13), wd(14), wd(15)};
    send_req(3'd4, 3'd4, 4'd5, 1'b0);
    repeat (15) tick();
    chk("t3_stall_cnt", 64'(fq.size()), 64'(4));
    chk("t3_stall_vld", 64'(flit_valid), 64'(0));
    chk("t3_cred0", 64'(dut.credit_q[0]), 64'(0));
    man_ret = 2'b01;
    tick();
    man_ret = 2'b00;
    repeat (6) tick();
    chk("t3_one_more", 64'(fq.size()), 64'(5));
    chk("t3_stall2_vld", 64'(flit_valid), 64'(0));
    man_ret = 2'b01;
    tick();
    man_ret = 2'b00;
    wait_pkt(3, 20);
    chk("t3_count", 64'(fq.size()), 64'(6));
    chk("t3_head", fq[0], hd(4, 4, 1, 2, 5, 2'b00));
    chk("t3_b3", fq[4], bd(2'b01, wd(14)));
    chk("t3_tail", fq[5], bd(2'b10, wd(15)));
    man_ret = 2'b01;
    repeat (4) tick();
    man_ret = 2'b00;
    tick();
    chk("t3_restore", 64'(dut.credit_q[0]), 64'(4));

    // same-cycle send and return, then overflow
    fr_man = 1'b0;
    send_req(3'd5, 3'd5, 4'd0, 1'b0);
    chk("t4_valid", 64'(flit_valid), 64'(1));
    fr_man = 1'b1;
    man_ret = 2'b01;
    tick();
    man_ret = 2'b00;
    tick();
    chk("t4_pkt", 64'(npkt), 64'(4));
    chk("t4_cred_same", 64'(dut.credit_q[0]), 64'(4));
    chk("t4_no_err", 64'(credit_err), 64'(0));
    man_ret = 2'b01;
    tick();
    man_ret = 2'b00;
    tick();
    chk("t4_sat", 64'(dut.credit_q[0]), 64'(4));
    chk("t4_err", 64'(credit_err), 64'(1));
    repeat (3) tick();
    chk("t4_sticky", 64'(credit_err), 64'(1));

    // random backpressure and bursty payload
    clear_log();
    dq = '{wd(21), wd(22), wd(23), wd(24), wd(25), wd(26)};
    tog_en = 1;
    rnd_en = 1;
    auto_ret = 1;
    stab_en = 1;
    send_req(3'd6, 3'd1, 4'd6, 1'b1);
    wait_pkt(5, 400);
    tog_en = 0;
    rnd_en = 0;
    stab_en = 0;
    repeat (4) tick();
    auto_ret = 0;
    tick();
    chk("t5_count", 64'(fq.size()), 64'(7));
    chk("t5_head", fq[0], hd(6, 1, 1, 2, 6, 2'b00));
    for (int i = 1; i < 6; i++) begin
      chk("t5_body", fq[i], bd(2'b01, wd(20 + i)));
    end
    chk("t5_tail", fq[6], bd(2'b10, wd(26)));
    ones = 0;
    foreach (vq[i]) ones += int'(vq[i]);
    chk("t5_vc", 64'(ones), 64'(7));
    chk("t5_cred1", 64'(dut.credit_q[1]), 64'(4));

    // reset in the middle of a packet
    clear_log();
    base = npkt;
    dq = '{wd(31), wd(32), wd(33), wd(34)};
    send_req(3'd7, 3'd7, 4'd4, 1'b0);
    begin
      int k = 0;
      while (fq.size() < 3 && k < 50) begin
        tick();
        k++;
      end
    end
    chk("t6_two_body", 64'(fq.size()), 64'(3));
    rst_n = 1'b0;
    dq.delete();
    #1;
    chk("t6_rst_vld", 64'(flit_valid), 64'(0));
    chk("t6_rst_dr", 64'(data_ready), 64'(0));
    chk("t6_rst_rr", 64'(req_ready), 64'(0));
    chk("t6_rst_err", 64'(credit_err), 64'(0));
    chk("t6_rst_cred", 64'(dut.credit_q[0]), 64'(4));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_rr", 64'(req_ready), 64'(1));
    chk("t6_cred", 64'(dut.credit_q[0]), 64'(4));
    chk("t6_abandon", 64'(fq.size()), 64'(3));
    chk("t6_no_pkt", 64'(npkt), 64'(base));
    clear_log();
    dq = '{wd(41)};
    send_req(3'd1, 3'd1, 4'd1, 1'b0);
    wait_pkt(base + 1, 20);
    chk("t6_count", 64'(fq.size()), 64'(2));
    chk("t6_head", fq[0], hd(1, 1, 1, 2, 1, 2'b00));
    chk("t6_tail", fq[1], bd(2'b10, wd(41)));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/noc_packet_injector.md
Name: noc_packet_injector

Overview:
- Local-port transmitter of a NoC node: takes a packet request (destination, length, VC) plus a payload word stream and serialises it into head/body/tail flits driven into a router's local receiver port.
- Enforces per-VC credit-based flow control toward the router input buffers.
- Counterpart of the router-side local receiver; one instance per active node.

Parameters:
- FLIT_W, 64, total flit width including 2-bit type field
- ID_X_W, 3, width of X coordinate
- ID_Y_W, 3, width of Y coordinate
- LEN_W, 4, width of payload-length field (max payload flits = 2^LEN_W-1)
- VC_NUM, 2, number of virtual channels
- BUF_DEPTH, 4, router input buffer depth per VC (initial credit count)

Ports:
- noc_clk  in  1  clock
- noc_rst_n  in  1  asynchronous active-low reset
- id_x  in  ID_X_W  own X coordinate (static)
- id_y  in  ID_Y_W  own Y coordinate (static)
- req_valid  in  1  packet request valid
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_dst_x  in  ID_X_W  destination X
- req_dst_y  in  ID_Y_W  destination Y
- req_len  in  LEN_W  number of payload flits (0 = head-only packet)
- req_vc  in  $clog2(VC_NUM)  VC for whole packet
- data_valid  in  1  payload word valid
- data_ready  out  1  payload word consumed
- data_word  in  FLIT_W-2  payload
- flit_valid  out  1  flit valid toward router
- flit_ready  in  1  router accepts flit
- flit_vc  out  $clog2(VC_NUM)  VC of current flit
- flit_data  out  FLIT_W  flit
- credit_return  in  VC_NUM  one-cycle pulse per freed router buffer slot
- credit_err  out  1  sticky: credit overflow detected
- pkt_sent  out  1  one-cycle pulse when tail (or head-tail) flit transfers

Behaviour:
- Flit type in [FLIT_W-1:FLIT_W-2]: 2'b00 head, 2'b01 body, 2'b10 tail, 2'b11 head+tail.
- Head payload, MSB-first below type: dst_x, dst_y, src_x(id_x), src_y(id_y), len; remaining LSBs zero.
- Body/tail payload: data_word unchanged.
- Flit transfer = flit_valid && flit_ready. flit_valid never depends combinationally on flit_ready; once asserted, flit_valid, flit_vc and flit_data hold until transfer.
- FSM states IDLE, HEAD, BODY.
  - IDLE: req_ready=1. On request handshake, latch dst/len/vc into registers; zero remaining-count := len; go to HEAD next cycle.
  - HEAD: flit_valid = credit[vc]>0. On transfer: len==0 -> type 11, pkt_sent pulse, go to IDLE; else type 00, go to BODY.
  - BODY: flit_valid = data_valid && credit[vc]>0; data_ready = flit_ready && credit[vc]>0 (0 outside BODY). Type 10 when remaining==1, else 01. Each transfer decrements remaining; last transfer pulses pulse pkt_sent and goes to IDLE.
- Minimum packet gap is 1 cycle: IDLE re-entered before next request is accepted. Latency from request to head flit_valid is 1 cycle given credit.
- Credits: per-VC counter, width $clog2(BUF_DEPTH+1), reset to BUF_DEPTH.
  - Decrement on a flit transfer on that VC; increment on credit_return[v].
  - Simultaneous transfer and return on the same VC leaves the count unchanged.
  - Increment beyond BUF_DEPTH saturates at BUF_DEPTH and sets credit_err (cleared only by reset).
  - Credit 0: flit_valid deasserts; stall with no flits lost or duplicated.
- Reset (any time, including mid-packet):
  - State IDLE; registers cleared.
  - flit_valid=0, data_ready=0, req_ready=0 while noc_rst_n=0, then 1 in IDLE.
  - pkt_sent=0, credit_err=0, credits=BUF_DEPTH.
  - Partial packet is abandoned.

Test Plan:
- id=(1,2); request dst=(3,0), len=0, vc=0, flit_ready=1 -> 1 cycle later one flit, type 11, head fields (3,0,1,2,0), pkt_sent pulse; credit[0] 4->3.
- Request len=3, vc=1, data words A,B,C -> flits 00(head), 01 A, 01 B, 10 C on flit_vc=1; credit[1]=0 after 4 flits; pkt_sent on C.
- BUF_DEPTH=4, len=5, no credit_return -> exactly 4 flits sent, flit_valid low; one credit_return[vc] pulse -> exactly one more flit.
- Same cycle flit transfer on vc0 and credit_return[0] -> credit[0] unchanged; credit_return[0] while credit=4 -> stays 4, credit_err=1 sticky.
- data_valid toggling and flit_ready random in BODY -> payload order preserved, no duplicates, flit_data stable while flit_valid&&!flit_ready.
- Assert noc_rst_n low after 2 body flits of len=4 packet -> flit_valid=0 immediately; after release req_ready=1, credits=4, next packet starts with head flit.
